// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring sequence monitor.
// Optional stall tolerance in the top is enabled by defining RING_MON_STALL_EN.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    StUnlocked,
    StLocking,
    StLocked,
    StFault
  } state_e;

  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned idx_w(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(logic [MaxWidth-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder with a one-hot valid flag.
module ring_onehot_enc
  import ring_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] ring,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign valid = is_onehot(MaxWidth'(ring));

endmodule

// File: rtl/ring_seq_monitor.sv
// Ring counter sequence monitor: lock detection, revolution counting, sticky fault.
// Define RING_MON_STALL_EN to accept a repeated sample as a stall in LOCKING/LOCKED.
module ring_seq_monitor
  import ring_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned REV_W    = 8,
  localparam int unsigned IDX_W   = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             err,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_pulse
);

  localparam int unsigned STEP_W = $clog2(LOCK_CNT + 1);
  localparam logic [STEP_W-1:0] LockTgt = STEP_W'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ok_q, ok_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic              pulse_q, pulse_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic [WIDTH-1:0]  exp_vec;
  logic              step_ok;
  logic              stall;
  logic [STEP_W-1:0] step_inc;

  ring_onehot_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .ring (ring),
    .idx  (enc_idx),
    .valid(enc_valid)
  );

  assign exp_vec  = {prev_q[0], prev_q[WIDTH-1:1]};
  assign step_ok  = (ring == exp_vec);
  assign step_inc = step_q + 1'b1;

`ifdef RING_MON_STALL_EN
  assign stall = enc_valid && (ring == prev_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    step_d  = step_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    rev_d   = rev_q;
    pulse_d = 1'b0;

    // Fault clear is honoured on any cycle, sampled or not.
    if (state_q == StFault && clr_err) begin
      state_d = StUnlocked;
      step_d  = '0;
    end

    if (en) begin
      ok_d = enc_valid;
      if (enc_valid) begin
        prev_d = ring;
        idx_d  = enc_idx;
      end

      unique case (state_q)
        StUnlocked: begin
          if (enc_valid) begin
            state_d = StLocking;
            step_d  = '0;
          end
        end
        StLocking: begin
          if (!stall) begin
            if (step_ok) begin
              step_d = step_inc;
              if (step_inc == LockTgt) begin
                state_d = StLocked;
              end
            end else if (enc_valid) begin
              step_d = '0;
            end else begin
              state_d = StUnlocked;
            end
          end
        end
        StLocked: begin
          if (step_ok) begin
            // Legal step out of bit 0 wraps to the top bit: one full revolution.
            if (prev_q[0]) begin
              rev_d   = rev_q + 1'b1;
              pulse_d = 1'b1;
            end
          end else if (!stall) begin
            state_d = StFault;
          end
        end
        StFault: ;
        default: state_d = StUnlocked;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StUnlocked;
      prev_q  <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      rev_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      rev_q   <= rev_d;
      pulse_q <= pulse_d;
    end
  end

  assign idx       = idx_q;
  assign onehot_ok = ok_q;
  assign locked    = (state_q == StLocked);
  assign err       = (state_q == StFault);
  assign rev_cnt   = rev_q;
  assign rev_pulse = pulse_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Self-checking bench for ring_seq_monitor: directed table, random run against a model,
// and a revolution counter wrap sequence.
module tb_ring_seq_monitor;

  localparam int W = 4;
  localparam int LockN = 2;
  localparam int RevW = 8;
`ifdef RING_MON_STALL_EN
  localparam bit Stall = 1'b1;
`else
  localparam bit Stall = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, clr_err;
  logic [W-1:0] ring;
  logic [1:0]   idx;
  logic         onehot_ok, locked, err, rev_pulse;
  logic [RevW-1:0] rev_cnt;

  int checks = 0;
  int errors = 0;

  ring_seq_monitor #(
    .WIDTH(W),
    .LOCK_CNT(LockN),
    .REV_W(RevW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ring     (ring),
    .clr_err  (clr_err),
    .idx      (idx),
    .onehot_ok(onehot_ok),
    .locked   (locked),
    .err      (err),
    .rev_cnt  (rev_cnt),
    .rev_pulse(rev_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: position-based view of the ring (-1 means no legal sample yet).
  int m_mode;  // 0 unlocked, 1 locking, 2 locked, 3 fault
  int m_pos, m_run, m_idx, m_rc;
  bit m_ok, m_pl;

  function automatic void model(bit r, bit e, bit c, logic [W-1:0] v);
    int  old_mode, p, nxt;
    bit  oh, legal, stl;
    if (r) begin
      m_mode = 0; m_pos = -1; m_run = 0; m_idx = 0; m_rc = 0; m_ok = 0; m_pl = 0;
      return;
    end
    m_pl = 0;
    old_mode = m_mode;
    oh = ($countones(v) == 1);
    p = -1;
    for (int i = 0; i < W; i++) if (v[i]) p = i;
    nxt   = (m_pos >= 0) ? (m_pos + W - 1) % W : -2;
    legal = oh && (p == nxt);
    stl   = Stall && oh && (p == m_pos);
    if (old_mode == 3 && c) m_mode = 0;
    if (e) begin
      m_ok = oh;
      case (old_mode)
        0: if (oh) begin m_mode = 1; m_run = 0; end
        1: if (!stl) begin
             if (legal) begin
               m_run++;
               if (m_run == LockN) m_mode = 2;
             end else if (oh) m_run = 0;
             else m_mode = 0;
           end
        2: if (legal) begin
             if (m_pos == 0) begin m_rc = (m_rc + 1) % (1 << RevW); m_pl = 1; end
           end else if (!stl) m_mode = 3;
        default: ;
      endcase
      if (oh) begin m_pos = p; m_idx = p; end
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply(bit r, bit e, bit c, logic [W-1:0] v);
    rst = r; en = e; clr_err = c; ring = v;
    @(posedge clk);
    model(r, e, c, v);
    #1;
    chk("m_idx", int'(idx), m_idx);
    chk("m_onehot_ok", int'(onehot_ok), int'(m_ok));
    chk("m_locked", int'(locked), int'(m_mode == 2));
    chk("m_err", int'(err), int'(m_mode == 3));
    chk("m_rev_pulse", int'(rev_pulse), int'(m_pl));
    chk("m_rev_cnt", int'(rev_cnt), m_rc);
  endtask

  typedef struct {
    bit r, e, c;
    logic [W-1:0] v;
    int idx;
    bit ok, lk, er, pl;
    int rc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit e, bit c, logic [W-1:0] v,
                              int ix, bit ok, bit lk, bit er, bit pl, int rc);
    vec_t t;
    t.r = r; t.e = e; t.c = c; t.v = v;
    t.idx = ix; t.ok = ok; t.lk = lk; t.er = er; t.pl = pl; t.rc = rc;
    tbl.push_back(t);
  endfunction

  initial begin
    int pulses;
    logic [W-1:0] v;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; ring = '0;
    model(1'b1, 1'b0, 1'b0, '0);

    add(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1000, 3, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0010, 1, 1, 1, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 4'b1000, 3, 1, 1, 0, 1, 1);
    add(0, 1, 0, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(0, 0, 0, 4'b1111, 2, 1, 1, 0, 0, 1);
    add(0, 0, 0, 4'b0000, 2, 1, 1, 0, 0, 1);
    add(0, 0, 1, 4'b0010, 2, 1, 1, 0, 0, 1);
    add(0, 0, 0, 4'b0101, 2, 1, 1, 0, 0, 1);
    add(0, 0, 0, 4'b1000, 2, 1, 1, 0, 0, 1);
    add(0, 1, 1, 4'b0010, 1, 1, 1, 0, 0, 1);
    add(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 4'b1000, 3, 1, 1, 0, 1, 2);
    add(0, 1, 0, 4'b0010, 1, 1, 0, 1, 0, 2);
    add(0, 1, 0, 4'b1100, 1, 0, 0, 1, 0, 2);
    add(0, 1, 0, 4'b0100, 2, 1, 0, 1, 0, 2);
    add(0, 0, 1, 4'b0000, 2, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b1100, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 4'b1000, 3, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b0000, 3, 0, 0, 0, 0, 2);
    add(0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b1000, 3, 1, 0, 0, 0, 2);
    add(0, 1, 0, 4'b0100, 2, 1, 1, 0, 0, 2);
    add(0, 1, 0, 4'b0010, 1, 1, 1, 0, 0, 2);
    add(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 2);
    add(0, 1, 0, 4'b1000, 3, 1, 1, 0, 1, 3);
    add(0, 1, 0, 4'b0100, 2, 1, 1, 0, 0, 3);
    add(1, 1, 1, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 1, Stall, !Stall, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].e, tbl[k].c, tbl[k].v);
      chk($sformatf("t%0d_idx", k), int'(idx), tbl[k].idx);
      chk($sformatf("t%0d_onehot_ok", k), int'(onehot_ok), int'(tbl[k].ok));
      chk($sformatf("t%0d_locked", k), int'(locked), int'(tbl[k].lk));
      chk($sformatf("t%0d_err", k), int'(err), int'(tbl[k].er));
      chk($sformatf("t%0d_rev_pulse", k), int'(rev_pulse), int'(tbl[k].pl));
      chk($sformatf("t%0d_rev_cnt", k), int'(rev_cnt), tbl[k].rc);
    end

    // Randomized run biased toward legal rotation so locking and revolutions occur.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(99);
      if (sel < 70) begin
        v = (m_pos >= 0) ? W'(1 << ((m_pos + W - 1) % W)) : 4'b1000;
      end else if (sel < 80) begin
        v = (m_pos >= 0) ? W'(1 << m_pos) : 4'b0001;
      end else if (sel < 90) begin
        v = W'(1 << $urandom_range(W - 1));
      end else begin
        v = W'($urandom_range(15));
      end
      apply($urandom_range(199) == 0, $urandom_range(99) < 85,
            $urandom_range(99) < 8, v);
    end

    // Full wrap of the revolution counter.
    apply(1, 0, 0, 4'b0000);
    apply(0, 1, 0, 4'b1000);
    apply(0, 1, 0, 4'b0100);
    apply(0, 1, 0, 4'b0010);
    chk("wrap_locked", int'(locked), 1);
    pulses = 0;
    for (int n = 0; n < (1 << RevW); n++) begin
      apply(0, 1, 0, 4'b0001);
      apply(0, 1, 0, 4'b1000);
      pulses += int'(rev_pulse);
      apply(0, 1, 0, 4'b0100);
      pulses += int'(rev_pulse);
      apply(0, 1, 0, 4'b0010);
    end
    chk("wrap_rev_cnt", int'(rev_cnt), 0);
    chk("wrap_pulses", pulses, 1 << RevW);
    chk("wrap_err", int'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
